// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding and the x0 register index.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_FLUSH = 2'd1,
        HZ_HALT  = 2'd2
    } hz_state_t;

    localparam logic [4:0] RV_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts i_inc cycles, sticks at all-ones, cleared synchronously.
module hz_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/bubble control for the 5-stage RV32I core.
// Optional stall performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIR_FLUSH_CYC = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_redirect,
    input  logic             i_wb_halt,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] o_perf_lu,
    output logic [CNT_W-1:0] o_perf_redir,
    output logic [CNT_W-1:0] o_perf_halt_cyc
`endif
);

    if ((REDIR_FLUSH_CYC < 1) || (REDIR_FLUSH_CYC > 3) || (CNT_W < 1)) begin : g_param_check
        $error("hazard_ctrl: REDIR_FLUSH_CYC must be 1..3 and CNT_W at least 1");
    end

    localparam logic [1:0] FLUSH_LOAD = 2'(REDIR_FLUSH_CYC - 1);

    hz_state_t  state, state_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;
    logic       lu;

    assign lu = i_ex_mem_read && (i_ex_rd != RV_X0) && i_id_valid &&
                ((i_id_use_rs1 && (i_ex_rd == i_id_rs1)) ||
                 (i_id_use_rs2 && (i_ex_rd == i_id_rs2)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= HZ_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;

        if (state == HZ_HALT) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else begin
            if (i_ex_redirect) begin
                // ID holds a wrong-path instruction, so any load-use stall is moot
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                if (FLUSH_LOAD != 2'd0) begin
                    state_nxt     = HZ_FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end else begin
                    state_nxt     = HZ_RUN;
                end
            end else begin
                if (state == HZ_FLUSH) begin
                    o_if_id_flush = 1'b1;
                    flush_cnt_nxt = flush_cnt - 2'd1;
                    if (flush_cnt == 2'd1) begin
                        state_nxt = HZ_RUN;
                    end
                end
                if (lu) begin
                    o_pc_stall     = 1'b1;
                    o_id_ex_bubble = 1'b1;
                    o_if_id_stall  = (state != HZ_FLUSH);
                end
            end
            if (i_wb_halt) begin
                state_nxt = HZ_HALT;
            end
        end
    end

    assign o_halted = (state == HZ_HALT);

`ifdef HAZARD_PERF_EN
    logic lu_stall;
    logic redir_evt;
    logic halt_cyc;

    assign lu_stall  = lu && !i_ex_redirect && (state != HZ_HALT);
    assign redir_evt = i_ex_redirect && (state != HZ_HALT);
    assign halt_cyc  = (state == HZ_HALT);

    hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (lu_stall),
        .o_cnt (o_perf_lu)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_redir (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (redir_evt),
        .o_cnt (o_perf_redir)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_halt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (halt_cyc),
        .o_cnt (o_perf_halt_cyc)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned R = 3;
    localparam int unsigned W = 4;
    localparam int          SAT_MAX = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic       use_rs1 = 1'b0;
    logic       use_rs2 = 1'b0;
    logic       mem_read = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       redirect = 1'b0;
    logic       wb_halt = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush, bubble, halted;
`ifdef HAZARD_PERF_EN
    logic [W-1:0] perf_lu, perf_redir, perf_halt;
`endif

    int passed = 0;
    int total  = 0;

    bit m_halted = 1'b0;
    int m_rem    = 0;
    int m_plu    = 0;
    int m_pred   = 0;
    int m_phalt  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REDIR_FLUSH_CYC (R),
        .CNT_W           (W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_rs1       (rs1),
        .i_id_rs2       (rs2),
        .i_id_use_rs1   (use_rs1),
        .i_id_use_rs2   (use_rs2),
        .i_ex_mem_read  (mem_read),
        .i_ex_rd        (ex_rd),
        .i_ex_redirect  (redirect),
        .i_wb_halt      (wb_halt),
        .o_pc_stall     (pc_stall),
        .o_if_id_stall  (if_id_stall),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_bubble (bubble),
        .o_halted       (halted)
`ifdef HAZARD_PERF_EN
        ,
        .o_perf_lu       (perf_lu),
        .o_perf_redir    (perf_redir),
        .o_perf_halt_cyc (perf_halt)
`endif
    );

    function automatic bit f_lu();
        return mem_read && (ex_rd != 5'd0) && id_valid &&
               ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    endfunction

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        id_valid = 1'b0; rs1 = '0; rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        mem_read = 1'b0; ex_rd = '0; redirect = 1'b0; wb_halt = 1'b0; rst = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                          input logic ua, input logic ub);
        mem_read = 1'b1; ex_rd = rd; id_valid = 1'b1;
        rs1 = a; rs2 = b; use_rs1 = ua; use_rs2 = ub;
    endtask

    // One clock: inputs already driven; check outputs mid-cycle, then advance the model.
    task automatic cycle(input string tag);
        logic [4:0] e;
        bit         l;
        #3;
        l = f_lu();
        // expected vector: {pc_stall, if_id_stall, if_id_flush, bubble, halted}
        if (m_halted)        e = 5'b11011;
        else if (redirect)   e = 5'b00110;
        else if (m_rem > 0)  e = l ? 5'b10110 : 5'b00100;
        else                 e = l ? 5'b11010 : 5'b00000;
        check(tag, 32'({pc_stall, if_id_stall, if_id_flush, bubble, halted}), 32'(e));
`ifdef HAZARD_PERF_EN
        check({tag, "_plu"},   32'(perf_lu),    m_plu);
        check({tag, "_pred"},  32'(perf_redir), m_pred);
        check({tag, "_phalt"}, 32'(perf_halt),  m_phalt);
`endif
        @(posedge clk);
        if (rst) begin
            m_halted = 1'b0; m_rem = 0; m_plu = 0; m_pred = 0; m_phalt = 0;
        end else if (m_halted) begin
            m_phalt = sat(m_phalt + 1);
        end else begin
            if (l && !redirect) m_plu = sat(m_plu + 1);
            if (redirect) m_pred = sat(m_pred + 1);
            if (redirect)       m_rem = R - 1;
            else if (m_rem > 0) m_rem = m_rem - 1;
            if (wb_halt) m_halted = 1'b1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle();
        cycle("reset");

        // load-use on rs1, then the bubble removes the load from EX
        set_lu(5'd5, 5'd5, 5'd9, 1'b1, 1'b0); cycle("lu_rs1");
        mem_read = 1'b0;                      cycle("lu_done");
        set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); cycle("lu_x0");
        set_lu(5'd5, 5'd5, 5'd9, 1'b0, 1'b0); cycle("lu_nouse");
        set_lu(5'd7, 5'd1, 5'd7, 1'b0, 1'b1); cycle("lu_rs2");
        idle();                               cycle("idle1");

        // single redirect: three flush cycles
        redirect = 1'b1; cycle("redir_c1");
        idle();          cycle("redir_c2");
                         cycle("redir_c3");
                         cycle("redir_end");

        // redirect with simultaneous load-use
        set_lu(5'd3, 5'd3, 5'd0, 1'b1, 1'b0); redirect = 1'b1; cycle("redir_lu");
        idle(); cycle("redir_lu_c2"); cycle("redir_lu_c3"); cycle("redir_lu_end");

        // re-redirect on flush cycle 2
        redirect = 1'b1; cycle("rr_c1");
        redirect = 1'b1; cycle("rr_c2_new");
        idle();          cycle("rr_c3");
                         cycle("rr_c4");
                         cycle("rr_end");

        // halt pulse: sticky until reset, ignores redirect/lu
        wb_halt = 1'b1; cycle("halt_pulse");
        idle();         cycle("halted1");
        set_lu(5'd2, 5'd2, 5'd2, 1'b1, 1'b1); redirect = 1'b1; cycle("halted_ign");
        idle();         cycle("halted2");
        rst = 1'b1;     cycle("halt_rst");
        idle();         cycle("post_rst");

`ifdef HAZARD_PERF_EN
        rst = 1'b1; cycle("perf_clr");
        idle();
        for (int i = 0; i < 20; i++) begin
            set_lu(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
            cycle("perf_lu");
        end
        idle(); cycle("perf_idle");
        check("perf_lu_sat", 32'(perf_lu), 32'd15);
        for (int i = 0; i < 2; i++) begin
            redirect = 1'b1; cycle("perf_redir");
            idle(); cycle("perf_fl"); cycle("perf_fl");
        end
        check("perf_redir_cnt", 32'(perf_redir), 32'd2);
`endif

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 50) == 0);
            wb_halt  = ($urandom_range(0, 40) == 0);
            redirect = ($urandom_range(0, 5) == 0);
            mem_read = $urandom_range(0, 1) != 0;
            id_valid = $urandom_range(0, 3) != 0;
            use_rs1  = $urandom_range(0, 1) != 0;
            use_rs2  = $urandom_range(0, 1) != 0;
            ex_rd    = 5'($urandom_range(0, 3));
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
